// File: rtl/ethernet_frame_arbiter.sv
// Frame-granular two-port round-robin AXI4-Stream arbiter with a combinational egress path.
// Optional per-port frame counters are built when ETHERNET_FRAME_ARBITER_STATS_EN is defined.
//
//   state | meaning
//   ------+--------------------------------------------
//   IDLE  | no owner; arbitrate when arb_enable=1
//   OWN0  | port 0 owns egress until its tlast handshake
//   OWN1  | port 1 owns egress until its tlast handshake
module ethernet_frame_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          arb_enable,

  input  logic [C_AXIS_TDATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic                          s0_axis_tvalid,
  input  logic                          s0_axis_tlast,
  input  logic                          s0_axis_tuser,
  output logic                          s0_axis_tready,

  input  logic [C_AXIS_TDATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic                          s1_axis_tvalid,
  input  logic                          s1_axis_tlast,
  input  logic                          s1_axis_tuser,
  output logic                          s1_axis_tready,

  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  input  logic                          m_axis_tready,

  output logic [1:0]                    grant,
  input  logic                          stats_clear,
  output logic [31:0]                   frame_count0,
  output logic [31:0]                   frame_count1
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [1:0] state, state_nxt;
  logic       last_grant, last_grant_nxt;   // 1 = port 1 won most recently
  logic       done0, done1;

  assign done0 = (state == ST_OWN0) && s0_axis_tvalid && m_axis_tready && s0_axis_tlast;
  assign done1 = (state == ST_OWN1) && s1_axis_tvalid && m_axis_tready && s1_axis_tlast;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      ST_IDLE: begin
        if (arb_enable) begin
          if (s0_axis_tvalid && (!s1_axis_tvalid || last_grant)) begin
            state_nxt      = ST_OWN0;
            last_grant_nxt = 1'b0;
          end else if (s1_axis_tvalid) begin
            state_nxt      = ST_OWN1;
            last_grant_nxt = 1'b1;
          end
        end
      end
      ST_OWN0: if (done0) state_nxt = ST_IDLE;
      ST_OWN1: if (done1) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Pure pass-through mux; port 0 fields leak through in IDLE with tvalid low.
  always_comb begin
    m_axis_tdata   = s0_axis_tdata;
    m_axis_tkeep   = s0_axis_tkeep;
    m_axis_tlast   = s0_axis_tlast;
    m_axis_tuser   = s0_axis_tuser;
    m_axis_tvalid  = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state)
      ST_OWN0: begin
        m_axis_tvalid  = s0_axis_tvalid;
        s0_axis_tready = m_axis_tready;
      end
      ST_OWN1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tuser   = s1_axis_tuser;
        m_axis_tvalid  = s1_axis_tvalid;
        s1_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign grant = {state == ST_OWN1, state == ST_OWN0};

`ifdef ETHERNET_FRAME_ARBITER_STATS_EN
  logic [31:0] cnt0, cnt1;

  // Clear has priority over a coincident count; counters saturate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (stats_clear) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (done0 && (cnt0 != 32'hFFFF_FFFF)) cnt0 <= cnt0 + 32'd1;
      if (done1 && (cnt1 != 32'hFFFF_FFFF)) cnt1 <= cnt1 + 32'd1;
    end
  end

  assign frame_count0 = cnt0;
  assign frame_count1 = cnt1;
`else
  logic unused_stats_clear;
  assign unused_stats_clear = stats_clear;
  assign frame_count0 = '0;
  assign frame_count1 = '0;
`endif

endmodule

// File: tb/tb_ethernet_frame_arbiter.sv
// Directed + randomized bench for ethernet_frame_arbiter: frame-order scoreboard, grant traces,
// inter-frame gap, async reset and frame counters (expected 0 unless ETHERNET_FRAME_ARBITER_STATS_EN).
module tb_ethernet_frame_arbiter;

  localparam int W = 8;
  localparam int K = 1;

  typedef struct {
    logic [W-1:0] data;
    logic [K-1:0] keep;
    logic         last;
    logic         user;
    logic         first;
  } beat_t;

  localparam int T1_G [13] = '{0,1,1,1,0,2,2,2,0,1,1,1,0};
  localparam int T3_G [12] = '{0,1,1,1,1,1,1,1,0,2,2,0};
  localparam int T4_G [14] = '{0,1,1,1,1,1,0,0,0,0,0,2,2,0};

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         arb_enable = 1'b1;
  logic         m_axis_tready = 1'b1;
  logic         stats_clear = 1'b0;
  logic [W-1:0] dat [2];
  logic [K-1:0] kp  [2];
  logic         vld [2];
  logic         lst [2];
  logic         usr [2];
  logic         s0_tready, s1_tready;
  logic [W-1:0] m_axis_tdata;
  logic [K-1:0] m_axis_tkeep;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic [1:0]   grant;
  logic [31:0]  frame_count0, frame_count1;

  ethernet_frame_arbiter #(.C_AXIS_TDATA_WIDTH(W), .C_AXIS_TKEEP_WIDTH(K)) dut (
    .clk(clk), .rstn(rstn), .arb_enable(arb_enable),
    .s0_axis_tdata(dat[0]), .s0_axis_tkeep(kp[0]), .s0_axis_tvalid(vld[0]),
    .s0_axis_tlast(lst[0]), .s0_axis_tuser(usr[0]), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(dat[1]), .s1_axis_tkeep(kp[1]), .s1_axis_tvalid(vld[1]),
    .s1_axis_tlast(lst[1]), .s1_axis_tuser(usr[1]), .s1_axis_tready(s1_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .grant(grant), .stats_clear(stats_clear),
    .frame_count0(frame_count0), .frame_count1(frame_count1)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  beat_t       sq [2][$];     // beats still to be offered by each source
  beat_t       eq [2][$];     // beats each source is expected to deliver to egress
  int          ord [$];       // expected egress frame order (source port per frame)
  logic [31:0] exp_cnt [2];
  int          prev_port = 1;
  logic        acc [2];
  logic        gap_due = 1'b0;
  logic [1:0]  g_s;
  logic        gap_en = 1'b0, rdy_rand = 1'b0, en_rand = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input int p, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data  = W'($urandom);
      b.keep  = K'($urandom);
      b.user  = 1'($urandom);
      b.last  = (i == n - 1);
      b.first = (i == 0);
      sq[p].push_back(b);
      eq[p].push_back(b);
    end
    ord.push_back(p);
  endtask

  // Source behaviour: first beats always valid, mid-frame bubbles optional, AXI hold rule kept.
  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      logic v;
      if (sq[p].size() == 0)           v = 1'b0;
      else if (vld[p] && !acc[p])      v = 1'b1;
      else if (sq[p][0].first)         v = 1'b1;
      else                             v = !(gap_en && ($urandom_range(3) == 0));
      vld[p] = v;
      if (sq[p].size() > 0) begin
        dat[p] = sq[p][0].data; kp[p] = sq[p][0].keep;
        lst[p] = sq[p][0].last; usr[p] = sq[p][0].user;
      end else begin
        dat[p] = '0; kp[p] = '0; lst[p] = 1'b0; usr[p] = 1'b0;
      end
    end
    if (rdy_rand) m_axis_tready = ($urandom_range(3) != 0);
    if (en_rand)  arb_enable    = ($urandom_range(4) != 0);
  endtask

  // One clock: observe at negedge, advance sources after posedge.
  task automatic step();
    beat_t e;
    int    p;
    @(negedge clk);
    g_s = grant;
    chk("counts", {frame_count1, frame_count0}, {exp_cnt[1], exp_cnt[0]});
    if (gap_due) chk("gap", 64'(grant), 64'd0);
    gap_due = 1'b0;
    if (m_axis_tvalid && m_axis_tready) begin
      if (ord.size() == 0) chk("extra_beat", 64'(ord.size()), 64'd1);
      else begin
        p = ord[0];
        e = eq[p].pop_front();
        chk("beat", {grant, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
            {(p == 1) ? 2'b10 : 2'b01, e.data, e.keep, e.last, e.user});
        if (e.last) begin
          void'(ord.pop_front());
          prev_port = p;
          gap_due = 1'b1;
`ifdef ETHERNET_FRAME_ARBITER_STATS_EN
          if (exp_cnt[p] != 32'hFFFF_FFFF) exp_cnt[p]++;
`endif
        end
      end
    end
`ifdef ETHERNET_FRAME_ARBITER_STATS_EN
    if (stats_clear) begin exp_cnt[0] = '0; exp_cnt[1] = '0; end
`endif
    acc[0] = vld[0] && s0_tready;
    acc[1] = vld[1] && s1_tready;
    @(posedge clk); #1;
    for (int q = 0; q < 2; q++) if (acc[q] && sq[q].size() > 0) void'(sq[q].pop_front());
    drive();
  endtask

  task automatic drain(input string tag, input int max);
    int k = 0;
    while (ord.size() > 0 && k < max) begin step(); k++; end
    chk(tag, 64'(ord.size()), 64'd0);
    step();
  endtask

  initial begin
    int r [2];
    int nxt;
    exp_cnt[0] = '0; exp_cnt[1] = '0;
    acc[0] = 1'b0; acc[1] = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0;
    drive();
    #12;
    chk("rst_outputs", {grant, m_axis_tvalid, s0_tready, s1_tready}, 5'b0);
    chk("rst_counts", {frame_count1, frame_count0}, 64'd0);
    #10 rstn = 1'b1;
    @(posedge clk); #1;

    // Contention from reset: port 0 first, then strict alternation with one IDLE gap.
    add_frame(0, 3); add_frame(1, 3); add_frame(0, 3);
    drive();
    for (int i = 0; i < 13; i++) begin step(); chk("t1_grant", 64'(g_s), 64'(T1_G[i])); end
    drain("t1_drain", 20);

    // Port 0 alone, single-beat frames back to back.
    for (int i = 0; i < 4; i++) add_frame(0, 1);
    drive();
    for (int i = 0; i < 9; i++) begin
      step();
      chk("t2_trace", {g_s, s1_tready}, {(i % 2 == 1) ? 2'b01 : 2'b00, 1'b0});
    end
    drain("t2_drain", 10);

    // Egress stall mid-frame while port 1 waits.
    add_frame(0, 4);
    drive();
    step();
    chk("t3_grant", 64'(g_s), 64'(T3_G[0]));
    add_frame(1, 2);
    drive();
    for (int i = 1; i < 12; i++) begin
      m_axis_tready = !(i >= 2 && i <= 4);
      step();
      chk("t3_grant", 64'(g_s), 64'(T3_G[i]));
    end
    m_axis_tready = 1'b1;
    drain("t3_drain", 10);

    // Grant enable dropped mid-frame: frame completes, then hold IDLE until re-enabled.
    add_frame(0, 5); add_frame(1, 2);
    drive();
    for (int i = 0; i < 14; i++) begin
      if (i == 2)  arb_enable = 1'b0;
      if (i == 10) arb_enable = 1'b1;
      step();
      chk("t4_grant", 64'(g_s), 64'(T4_G[i]));
    end
    drain("t4_drain", 10);

    // Asynchronous reset during port 1 beat 3.
    add_frame(1, 5);
    drive();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_grant", 64'(g_s), (i == 0) ? 64'd0 : 64'd2);
    end
    #2;
    chk("t5_pre_rst", 64'(grant), 64'd2);
    rstn = 1'b0;
    #1;
    chk("t5_rst_outputs", {grant, m_axis_tvalid, s1_tready}, 4'b0);
    chk("t5_rst_counts", {frame_count1, frame_count0}, 64'd0);
    sq[1].delete(); eq[1].delete(); ord.delete();
    exp_cnt[0] = '0; exp_cnt[1] = '0;
    gap_due = 1'b0; acc[0] = 1'b0; acc[1] = 1'b0; vld[1] = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    add_frame(0, 2); add_frame(1, 2);
    drive();
    step(); chk("t5_idle", 64'(g_s), 64'd0);
    step(); chk("t5_first_win", 64'(g_s), 64'd1);
    drain("t5_drain", 12);

    // Frame counters: clear, 5 + 2 frames, then clear coinciding with a port 0 tlast.
    stats_clear = 1'b1; step(); stats_clear = 1'b0;
    add_frame(0, 1 + $urandom_range(3)); add_frame(1, 1 + $urandom_range(3));
    add_frame(0, 1 + $urandom_range(3)); add_frame(1, 1 + $urandom_range(3));
    for (int i = 0; i < 3; i++) add_frame(0, 1 + $urandom_range(3));
    drive();
    drain("t6_drain", 80);
`ifdef ETHERNET_FRAME_ARBITER_STATS_EN
    chk("t6_counts", {frame_count1, frame_count0}, {32'd2, 32'd5});
`else
    chk("t6_counts", {frame_count1, frame_count0}, 64'd0);
`endif
    add_frame(0, 2);
    drive();
    step(); step();
    stats_clear = 1'b1; step(); stats_clear = 1'b0;
    step();
    chk("t6_clear_wins", {frame_count1, frame_count0}, 64'd0);
    drain("t6b_drain", 10);

    // Randomized traffic: bubbles, backpressure and enable toggling; order must still alternate.
    gap_en = 1'b1; rdy_rand = 1'b1; en_rand = 1'b1;
    r[0] = 10 + $urandom_range(5);
    r[1] = 10 + $urandom_range(5);
    nxt = 1 - prev_port;
    while (r[0] + r[1] > 0) begin
      if (r[0] > 0 && r[1] > 0) begin
        add_frame(nxt, 1 + $urandom_range(5)); r[nxt]--; nxt = 1 - nxt;
      end else if (r[0] > 0) begin
        add_frame(0, 1 + $urandom_range(5)); r[0]--;
      end else begin
        add_frame(1, 1 + $urandom_range(5)); r[1]--;
      end
    end
    drive();
    drain("rand_drain", 5000);
    gap_en = 1'b0; rdy_rand = 1'b0; en_rand = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ethernet_frame_arbiter.md
# ethernet_frame_arbiter

Frame-granular round-robin arbiter that merges two AXI4-Stream Ethernet ingress ports into one egress stream, feeding the frame dropper and rear FIFO of the EFCC path. Grants are whole frames: once a port wins, it owns the egress until its tlast beat is accepted, so frames never interleave. The block also provides a global grant-enable so upstream control can stop new frames without truncating one already in flight.

## Interface
Parameters:
- C_AXIS_TDATA_WIDTH, 8, data width of all streams
- C_AXIS_TKEEP_WIDTH, C_AXIS_TDATA_WIDTH/8, keep width of all streams

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  sole clock
  - rstn  in  1  asynchronous active-low reset
- Control:
  - arb_enable  in  1  1 = new grants allowed; 0 = finish the current frame, then hold IDLE
- Ingress port 0:
  - s0_axis_tdata/tkeep/tvalid/tlast/tuser  in  W/K/1/1/1  ingress port 0
  - s0_axis_tready  out  1  ingress port 0 ready
- Ingress port 1:
  - s1_axis_tdata/tkeep/tvalid/tlast/tuser  in  W/K/1/1/1  ingress port 1
  - s1_axis_tready  out  1  ingress port 1 ready
- Egress, toward the dropper:
  - m_axis_tdata/tkeep/tvalid/tlast/tuser  out  W/K/1/1/1  egress
  - m_axis_tready  in  1  egress ready
- Status:
  - grant  out  2  one-hot owner; 00 in IDLE
  - stats_clear  in  1  synchronous clear of both counters
  - frame_count0  out  32  frames forwarded from port 0
  - frame_count1  out  32  frames forwarded from port 1

## Operation
- FSM states:
  - IDLE: no owner.
  - OWN0: port 0 owns the egress.
  - OWN1: port 1 owns the egress.
- Register last_grant holds the port that won most recently.
- IDLE arbitration, evaluated every cycle when arb_enable=1:
  - Only s0 tvalid=1 → OWN0.
  - Only s1 tvalid=1 → OWN1.
  - Both tvalid=1 → the port ≠ last_grant wins.
  - Neither valid → stay in IDLE.
  - last_grant updates on the IDLE→OWNx transition.
- arb_enable=0 in IDLE: stay in IDLE regardless of tvalid. arb_enable has no effect in OWNx.
- OWNx datapath (combinational):
  - m_axis_* = sx_axis_* (all fields).
  - sx_axis_tready = m_axis_tready.
  - The other port's tready = 0.
- IDLE datapath:
  - m_axis_tvalid = 0.
  - Both s tready = 0.
  - m_axis data fields = port 0 fields (don't-care).
- OWNx → IDLE on the beat where sx_axis_tvalid & m_axis_tready & sx_axis_tlast.
- A single-beat frame (tlast on first beat) is legal: one beat in OWNx, then IDLE.
- tuser is forwarded unchanged; the arbiter never drops or modifies beats.
- A source deasserting tvalid mid-frame keeps ownership (no timeout).

## Timing
- Reset values:
  - state = IDLE; last_grant = port 1, so port 0 wins the first contention.
  - grant = 00; m_axis_tvalid = 0; both s tready = 0.
  - Counters = 0.
- Grant latency: 1 cycle. tvalid seen in IDLE at cycle n → grant valid at n+1; the first beat can transfer at n+1.
- Inter-frame gap: exactly 1 IDLE cycle after every tlast handshake.
- Egress latency: 0 cycles (combinational pass-through). No registers sit on the data path.
- Reset mid-frame: immediate return to IDLE and tready=0. The partial frame is abandoned; downstream sees an unterminated frame. Accepted behaviour.
- stats_clear is synchronous.
  - If a clear coincides with a counting event, the clear wins and the counter = 0.

## Configuration
- Macro ETHERNET_FRAME_ARBITER_STATS_EN.
- Defined:
  - frame_countx increments by 1 on each tlast handshake from port x.
  - Counters saturate at 0xFFFFFFFF and do not wrap.
  - stats_clear is honoured.
- Undefined:
  - Counter logic is removed; frame_count0/1 are tied to 0.
  - stats_clear is ignored.
  - Ports remain present, so the interface is identical.

## Test plan
- After reset, s0 and s1 both valid with 3-beat frames, m_axis_tready=1:
  - Egress order: port0 frame, 1 IDLE cycle, port1 frame, port0 frame (alternation).
  - grant sequence 01,00,10,00,01.
- s0 only, 1-beat frames back-to-back:
  - Every second cycle carries a beat (grant/IDLE alternation).
  - s1_axis_tready stays 0 throughout.
- Port0 owns a 4-beat frame; m_axis_tready=0 on beat 2 for 3 cycles; s1 valid throughout:
  - No s1 beat appears.
  - All 4 port0 beats arrive in order with data intact.
  - Port1 is granted the cycle after port0's tlast.
- arb_enable dropped to 0 during port0 beat 2 of a 5-beat frame:
  - The frame completes.
  - Then IDLE with grant=00 while s1 is valid.
  - Re-assert arb_enable: port1 is granted 1 cycle later.
- rstn asserted asynchronously (mid-cycle) during port1 beat 3:
  - grant=00, m_axis_tvalid=0 and counters=0 immediately.
  - After release, port0 wins the first contention.
- STATS_EN defined: 5 port0 frames + 2 port1 frames → frame_count0=5, frame_count1=2.
  - stats_clear pulsed in the same cycle as a port0 tlast → frame_count0=0.
  - STATS_EN undefined: both counters read 0.
